// File: rtl/pic_prio_ctrl_if.sv
// Bus between the interrupt controller and the core/request side.
// master = core side (drives requests, enables, ack/eoi), slave = controller.
interface pic_prio_ctrl_if #(
    parameter int N_SRC = 8
);
    localparam int ID_W = $clog2(N_SRC);

    logic [N_SRC-1:0] int_req;
    logic [N_SRC-1:0] src_en;
    logic [N_SRC-1:0] edge_mode;
    logic             int_ack;
    logic             int_eoi;
    logic             int_o;
    logic [ID_W-1:0]  int_id;
    logic             in_service;
    logic [N_SRC-1:0] int_pending;

    modport master (
        output int_req, src_en, edge_mode, int_ack, int_eoi,
        input  int_o, int_id, in_service, int_pending
    );

    modport slave (
        input  int_req, src_en, edge_mode, int_ack, int_eoi,
        output int_o, int_id, in_service, int_pending
    );
endinterface

// File: rtl/pic_prio_ctrl.sv
// Fixed-priority interrupt controller: synchronises request lines, latches
// edge-mode requests, masks with per-source enables and presents the lowest
// index eligible source to the core with an ack/EOI handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing presented; picks a winner as soon as one is eligible
// REQ   | int_o high, int_id frozen until the core acks
// SVC   | in service; waits for EOI, new requests only accumulate
module pic_prio_ctrl #(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    pic_prio_ctrl_if.slave   bus
);
    localparam int ID_W = $clog2(N_SRC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_SRC-1:0]  r_sync [SYNC_STAGES];
    logic [N_SRC-1:0]  r_req_s_d;
    logic [N_SRC-1:0]  r_pend_edge;
    logic [ID_W-1:0]   r_id;
    logic [N_SRC-1:0]  w_req_s;
    logic [N_SRC-1:0]  w_edge;
    logic [N_SRC-1:0]  w_clr;
    logic [N_SRC-1:0]  w_pending;
    logic [N_SRC-1:0]  w_eligible;
    logic [ID_W-1:0]   w_winner;
    logic              w_any;
    logic              w_ack_take;

    assign w_req_s    = r_sync[SYNC_STAGES-1];
    // Edge history only arms latching for sources configured as edge-triggered.
    assign w_edge     = w_req_s & ~r_req_s_d & bus.edge_mode;
    assign w_ack_take = (r_state == ST_REQ) && bus.int_ack;
    // Level sources bypass the latch: pending simply follows the synced line.
    assign w_pending  = (bus.edge_mode & r_pend_edge) | (~bus.edge_mode & w_req_s);
    assign w_eligible = w_pending & bus.src_en;
    assign w_any      = |w_eligible;

    // Request synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_req_s_d <= '0;
        end else begin
            r_sync[0] <= bus.int_req;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_req_s_d <= w_req_s;
        end
    end

    // Clear mask for the acked source; only meaningful in the ack cycle.
    always_comb begin
        w_clr = '0;
        if (w_ack_take) begin
            w_clr[r_id] = 1'b1;
        end
    end

    // Edge pending latch; a fresh edge in the ack cycle wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_edge <= '0;
        end else begin
            r_pend_edge <= (r_pend_edge & ~w_clr) | w_edge;
        end
    end

    // Fixed priority: lowest set index of the eligible vector wins.
    always_comb begin
        w_winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end

    // Presented id is captured only when leaving IDLE and then held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id <= '0;
        end else if (r_state == ST_IDLE && w_any) begin
            r_id <= w_winner;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; ack wins over a simultaneous EOI in REQ.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any)       w_state_nxt = ST_REQ;
            ST_REQ:  if (bus.int_ack) w_state_nxt = ST_SVC;
            ST_SVC:  if (bus.int_eoi) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs, all derived from registered state.
    always_comb begin
        bus.int_o       = (r_state == ST_REQ);
        bus.in_service  = (r_state == ST_SVC);
        bus.int_id      = r_id;
        bus.int_pending = w_pending;
    end
endmodule
